vga_sync: RTL and testbench
===========================

// Module: vga_sync
// PURPOSE
//  Raster timing generator that drives the pixel-graphics blocks (pong_graph_*): produces pix_x/pix_y,
//  video_on, hsync/vsync and a pixel-rate enable. Sits between the board clock and the graphics/RGB
//  path; default timing is 640x480@60 Hz from a 100 MHz clk (25 MHz pixel rate).
// PARAMETERS
//  CLK_DIV    4    clk cycles per pixel (>=1); p_tick rate = f_clk/CLK_DIV
//  H_DISPLAY  640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BP       48   horizontal back porch (pixels); H_TOTAL = sum = 800
//  V_DISPLAY  480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines); V_TOTAL = sum = 525
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous reset, active low
//  hsync        out  1   horizontal sync, registered
//  vsync        out  1   vertical sync, registered
//  video_on     out  1   1 when (pix_x<H_DISPLAY)&&(pix_y<V_DISPLAY)
//  p_tick       out  1   one-clk pixel enable
//  frame_start  out  1   one-clk pulse on the p_tick that wraps raster to (0,0)
//  pix_x        out  10  current column 0..H_TOTAL-1
//  pix_y        out  10  current line 0..V_TOTAL-1
// BEHAVIOUR
//  - Reset (async assert, sync release): div_cnt=0, pix_x=0, pix_y=0, hsync=vsync=~SYNC_POL;
//    video_on=1 (decode of 0,0); p_tick=0 unless CLK_DIV==1; frame_start=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1 every clk and wraps; p_tick = (div_cnt==CLK_DIV-1).
//    CLK_DIV==1: p_tick constantly 1 out of reset. First p_tick is CLK_DIV clks after reset release.
//  - Counters advance only on p_tick: pix_x+1; at pix_x==H_TOTAL-1 -> pix_x=0 and pix_y+1;
//    at pix_y==V_TOTAL-1 with pix_x wrap -> pix_y=0. Values held between ticks.
//  - hsync/vsync registered from NEXT counter values so they change on the same clk edge as
//    pix_x/pix_y (zero skew vs. counts). Held between ticks.
//    hsync = SYNC_POL when H_DISPLAY+H_FP <= pix_x <= H_DISPLAY+H_FP+H_SYNC-1 (656..751), else ~SYNC_POL.
//    vsync = SYNC_POL when V_DISPLAY+V_FP <= pix_y <= V_DISPLAY+V_FP+V_SYNC-1 (490..491), else ~SYNC_POL.
//  - video_on: combinational decode of registered pix_x/pix_y; graphics block blanks RGB on 0.
//  - frame_start = p_tick && pix_x==H_TOTAL-1 && pix_y==V_TOTAL-1 (combinational, one clk).
//  - Widths: counters 10 bits; H_TOTAL,V_TOTAL <= 1024 required. No output ever exceeds TOTAL-1.
//  - Reset mid-frame: all state returns to reset values immediately; raster restarts at (0,0), no
//    partial sync pulse completed.
// TESTING
//  1 Release reset, defaults -> first p_tick at clk 4; pix_x=1 after it; hsync=vsync=1, video_on=1.
//  2 Line timing -> hsync falls when pix_x becomes 656, low exactly 96 ticks (384 clks), period 800 ticks.
//  3 Frame timing -> vsync low for pix_y 490..491 (1600 ticks); frame_start period 420000 ticks
//    (1680000 clks); video_on high 307200 ticks per frame.
//  4 Wrap -> at (799,524) next tick gives (0,0), frame_start=1 for one clk only, pix_y never reaches 525.
//  5 reset_n low at pix=(700,491) mid-sync -> hsync/vsync go 1, pix=(0,0) asynchronously, same clk.
//  6 CLK_DIV=1 build -> p_tick always 1; pix_x increments every clk; line = 800 clks.

Source files
------------

// File: rtl/vga_sync.sv
// Raster timing generator: pixel-rate enable, pix_x/pix_y counters, registered hsync/vsync,
// active-video and frame-start decodes for the pixel-graphics path.
module vga_sync #(
   parameter int unsigned CLK_DIV   = 4,
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       p_tick,
   output logic       frame_start,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y
);

   localparam int unsigned CNT_W   = 10;
   localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_DISP_END   = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_DISP_END   = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] H_SYNC_FIRST = CNT_W'(H_DISPLAY + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_LAST  = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] V_SYNC_FIRST = CNT_W'(V_DISPLAY + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

   logic             x_last;
   logic             y_last;
   logic [CNT_W-1:0] x_nxt;
   logic [CNT_W-1:0] y_nxt;
   logic             hsync_nxt;
   logic             vsync_nxt;

   // Pixel-rate enable; a divide-by-one build ticks every clock.
   generate
      if (CLK_DIV <= 1) begin : g_nodiv
         assign p_tick = 1'b1;
      end else begin : g_div
         localparam int unsigned      DIV_W    = $clog2(CLK_DIV);
         localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

         logic [DIV_W-1:0] div_cnt;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end

         assign p_tick = (div_cnt == DIV_LAST);
      end
   endgenerate

   assign x_last = (pix_x == H_LAST);
   assign y_last = (pix_y == V_LAST);

   // Next raster position; syncs decode from it so they move on the same edge as the counters.
   always_comb begin
      x_nxt = pix_x;
      y_nxt = pix_y;
      if (p_tick) begin
         if (x_last) begin
            x_nxt = '0;
            y_nxt = y_last ? '0 : pix_y + 10'd1;
         end else begin
            x_nxt = pix_x + 10'd1;
         end
      end
   end

   always_comb begin
      hsync_nxt = ~SYNC_POL;
      vsync_nxt = ~SYNC_POL;
      if ((x_nxt >= H_SYNC_FIRST) && (x_nxt <= H_SYNC_LAST)) begin
         hsync_nxt = SYNC_POL;
      end
      if ((y_nxt >= V_SYNC_FIRST) && (y_nxt <= V_SYNC_LAST)) begin
         vsync_nxt = SYNC_POL;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_x <= '0;
         pix_y <= '0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
      end else begin
         pix_x <= x_nxt;
         pix_y <= y_nxt;
         hsync <= hsync_nxt;
         vsync <= vsync_nxt;
      end
   end

   assign video_on    = (pix_x < H_DISP_END) && (pix_y < V_DISP_END);
   assign frame_start = p_tick && x_last && y_last;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default timing, a divide-by-one build and a shrunken raster
// (16x11, CLK_DIV=2, active-high syncs) that makes full-frame and wrap checks affordable.
module tb_vga_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;

   logic       a_hs, a_vs, a_vo, a_pt, a_fs;
   logic [9:0] a_x, a_y;
   logic       b_hs, b_vs, b_vo, b_pt, b_fs;
   logic [9:0] b_x, b_y;
   logic       c_hs, c_vs, c_vo, c_pt, c_fs;
   logic [9:0] c_x, c_y;

   int n_vec = 0;
   int n_err = 0;

   vga_sync u_dflt (
      .clk(clk), .reset_n(rst_a), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
      .p_tick(a_pt), .frame_start(a_fs), .pix_x(a_x), .pix_y(a_y)
   );

   vga_sync #(
      .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
   ) u_small (
      .clk(clk), .reset_n(rst_b), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
      .p_tick(b_pt), .frame_start(b_fs), .pix_x(b_x), .pix_y(b_y)
   );

   vga_sync #(.CLK_DIV(1)) u_fast (
      .clk(clk), .reset_n(rst_c), .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
      .p_tick(c_pt), .frame_start(c_fs), .pix_x(c_x), .pix_y(c_y)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, per, lo, von, hs_n, vs_n, fs_n, fs_idx, max_x, max_y;
      logic prev;

      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state of all three builds
      check("rst_x", 32'(a_x), 0);
      check("rst_y", 32'(a_y), 0);
      check("rst_hs", 32'(a_hs), 1);
      check("rst_vs", 32'(a_vs), 1);
      check("rst_vo", 32'(a_vo), 1);
      check("rst_pt", 32'(a_pt), 0);
      check("rst_fs", 32'(a_fs), 0);
      check("rst_small_hs", 32'(b_hs), 0);
      check("rst_small_vs", 32'(b_vs), 0);
      check("rst_small_pt", 32'(b_pt), 0);
      check("rst_fast_pt", 32'(c_pt), 1);

      // First ticks after release: p_tick on clk 3 (consumed by edge 4), pix_x follows
      rst_a = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check("div_tick", 32'(a_pt), ((i % 4) == 3) ? 1 : 0);
         check("div_x", 32'(a_x), i / 4);
      end

      // Line timing, default build
      k = 0;
      while (a_hs !== 1'b0 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      check("hs_fall_found", 32'(k < 4000), 1);
      check("hs_fall_x", 32'(a_x), 656);
      check("hs_fall_y", 32'(a_y), 0);
      check("hs_fall_vo", 32'(a_vo), 0);
      per = 0; lo = 0; von = 0;
      while (per < 5000) begin
         if (a_hs == 1'b0) lo++;
         if (a_vo) von++;
         prev = a_hs;
         @(negedge clk);
         per++;
         if (prev && !a_hs) break;
      end
      check("line_period_clks", 32'(per), 3200);
      check("hs_low_clks", 32'(lo), 384);
      check("line_video_clks", 32'(von), 2560);
      check("hs_fall2_x", 32'(a_x), 656);
      check("hs_fall2_y", 32'(a_y), 1);
      check("vs_line1", 32'(a_vs), 1);

      // Divide-by-one build: counts every clock, 800-clk line
      rst_c = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("fast_x", 32'(c_x), i);
         check("fast_pt", 32'(c_pt), 1);
      end
      k = 0;
      while (c_hs !== 1'b0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("fast_fall_found", 32'(k < 1000), 1);
      check("fast_fall_x", 32'(c_x), 656);
      per = 0; lo = 0; von = 0;
      while (per < 2000) begin
         if (c_hs == 1'b0) lo++;
         if (c_vo) von++;
         prev = c_hs;
         @(negedge clk);
         per++;
         if (prev && !c_hs) break;
      end
      check("fast_line_clks", 32'(per), 800);
      check("fast_hs_low_clks", 32'(lo), 96);
      check("fast_video_clks", 32'(von), 640);

      // Small raster: first frame_start 351 clks after release, at (15,10)
      rst_b = 1'b1;
      k = 0;
      while (b_fs !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("fs_first_clk", 32'(k), 351);
      check("fs_x", 32'(b_x), 15);
      check("fs_y", 32'(b_y), 10);
      check("fs_pt", 32'(b_pt), 1);
      @(negedge clk);
      check("wrap_fs_one_clk", 32'(b_fs), 0);
      check("wrap_x", 32'(b_x), 0);
      check("wrap_y", 32'(b_y), 0);
      check("wrap_vo", 32'(b_vo), 1);

      // One full small frame: 176 ticks = 352 clks
      hs_n = 0; vs_n = 0; von = 0; fs_n = 0; fs_idx = -1; max_x = 0; max_y = 0;
      for (int i = 0; i < 352; i++) begin
         if (b_hs == 1'b1) hs_n++;
         if (b_vs == 1'b1) vs_n++;
         if (b_vo) von++;
         if (b_fs) begin
            fs_n++;
            fs_idx = i;
         end
         if (int'(b_x) > max_x) max_x = int'(b_x);
         if (int'(b_y) > max_y) max_y = int'(b_y);
         @(negedge clk);
      end
      check("frame_hs_clks", 32'(hs_n), 66);
      check("frame_vs_clks", 32'(vs_n), 64);
      check("frame_video_clks", 32'(von), 96);
      check("frame_fs_count", 32'(fs_n), 1);
      check("frame_fs_index", 32'(fs_idx), 351);
      check("frame_max_x", 32'(max_x), 15);
      check("frame_max_y", 32'(max_y), 10);
      check("frame2_x", 32'(b_x), 0);
      check("frame2_y", 32'(b_y), 0);

      // Reset in the middle of both sync pulses
      k = 0;
      while (!(b_x == 10'd11 && b_y == 10'd8) && k < 800) begin
         @(negedge clk);
         k++;
      end
      check("mid_found", 32'(k < 800), 1);
      check("mid_hs", 32'(b_hs), 1);
      check("mid_vs", 32'(b_vs), 1);
      rst_b = 1'b0;
      #1;
      check("async_x", 32'(b_x), 0);
      check("async_y", 32'(b_y), 0);
      check("async_hs", 32'(b_hs), 0);
      check("async_vs", 32'(b_vs), 0);
      check("async_pt", 32'(b_pt), 0);
      @(negedge clk);
      check("held_x", 32'(b_x), 0);
      rst_b = 1'b1;
      @(negedge clk);
      check("restart_pt", 32'(b_pt), 1);
      check("restart_x0", 32'(b_x), 0);
      @(negedge clk);
      check("restart_x1", 32'(b_x), 1);
      check("restart_hs", 32'(b_hs), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
